// File: rtl/cmem_nport.sv
// cmem_nport: shared set-associative line cache serving NCH line-read
// channels, one byte-granular write port and single-line invalidation.
// Misses fill from the external bus. All operations are serialised through
// one FSM, and read channels are arbitrated round robin.
module cmem_nport #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned SETS   = 64,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BLK_W  = 58,
  localparam int unsigned OFFS_W = $clog2(LINE_W / 8)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NCH-1:0]          rd_req_i,
  input  logic [NCH*BLK_W-1:0]    rd_addr_i,
  output logic [NCH*LINE_W-1:0]   rd_data_o,
  output logic [NCH-1:0]          rd_dv_o,
  input  logic                    wr_req_i,
  input  logic [BLK_W-1:0]        wr_addr_i,
  input  logic [OFFS_W-1:0]       wr_offs_i,
  input  logic [63:0]             wr_data_i,
  input  logic [1:0]              wr_len_i,
  output logic                    wr_ack_o,
  input  logic                    inv_i,
  input  logic [BLK_W-1:0]        inv_addr_i,
  output logic                    inv_ack_o,
  output logic [BLK_W-1:0]        ext_addr_o,
  output logic                    ext_rd_o,
  input  logic [LINE_W-1:0]       ext_rdata_i,
  input  logic                    ext_dv_i
);

  localparam int unsigned SET_W = $clog2(SETS);
  localparam int unsigned TAG_W = BLK_W - SET_W;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned IDX_W = $clog2(SETS * WAYS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FETCH,
    S_RESP,
    S_WRITE,
    S_INV
  } state_e;

  state_e              state_q;
  logic [CH_W-1:0]     rr_q;
  logic                op_wr_q;
  logic [CH_W-1:0]     op_ch_q;
  logic [TAG_W-1:0]    op_tag_q;
  logic [SET_W-1:0]    op_set_q;
  logic [OFFS_W-1:0]   op_offs_q;
  logic [63:0]         op_data_q;
  logic [1:0]          op_len_q;
  logic [WAY_W-1:0]    way_q;
  logic [LINE_W-1:0]   line_q;
  logic [NCH*LINE_W-1:0] rd_data_q;
  logic [NCH-1:0]      rd_dv_q;
  logic                wr_ack_q;
  logic                inv_ack_q;
  logic                ext_rd_q;
  logic [BLK_W-1:0]    ext_addr_q;
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAY_W-1:0]    vptr_q  [SETS];

  logic [TAG_W-1:0]    tag_mem  [SETS*WAYS];
  logic [LINE_W-1:0]   data_mem [SETS*WAYS];

  logic [2*NCH-1:0]    req2_c;
  logic                gnt_vld_c;
  logic [CH_W-1:0]     gnt_ch_c;
  logic [CH_W-1:0]     rr_next_c;
  logic [BLK_W-1:0]    gnt_addr_c;
  logic                hit_c;
  logic [WAY_W-1:0]    hit_way_c;
  logic [WAY_W-1:0]    vict_c;
  logic                all_valid_c;
  logic [LINE_W-1:0]   hit_line_c;
  logic [LINE_W-1:0]   merged_d;
  logic                resp_fire_c;
  logic [LINE_W-1:0]   resp_line_c;
  logic                mem_we_c;
  logic                tag_we_c;
  logic [IDX_W-1:0]    mem_idx_c;
  logic [LINE_W-1:0]   mem_wdata_c;

  assign rd_data_o  = rd_data_q;
  assign rd_dv_o    = rd_dv_q;
  assign wr_ack_o   = wr_ack_q;
  assign inv_ack_o  = inv_ack_q;
  assign ext_rd_o   = ext_rd_q;
  assign ext_addr_o = ext_addr_q;

  // Flat index of (set, way) into the tag and data arrays.
  function automatic logic [IDX_W-1:0] way_idx(input logic [SET_W-1:0] s,
                                               input logic [WAY_W-1:0] w);
    return IDX_W'(int'(s) * int'(WAYS) + int'(w));
  endfunction

  // Byte merge of up to 8 write bytes into a line; bytes past the line end fall off the shift.
  function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] line,
                                                   input logic [OFFS_W-1:0] offs,
                                                   input logic [63:0]       data,
                                                   input logic [1:0]        len);
    logic [63:0]       bmask;
    logic [LINE_W-1:0] sh_mask;
    logic [LINE_W-1:0] sh_data;
    case (len)
      2'd0:    bmask = 64'h0000_0000_0000_00FF;
      2'd1:    bmask = 64'h0000_0000_0000_FFFF;
      2'd2:    bmask = 64'h0000_0000_FFFF_FFFF;
      default: bmask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    sh_mask = LINE_W'(bmask) << {offs, 3'b000};
    sh_data = LINE_W'(data & bmask) << {offs, 3'b000};
    return (line & ~sh_mask) | (sh_data & sh_mask);
  endfunction

  // Round-robin pick among read channels starting at rr_q.
  always_comb begin
    int sum;
    req2_c     = {rd_req_i, rd_req_i} >> rr_q;
    gnt_vld_c  = 1'b0;
    gnt_ch_c   = '0;
    gnt_addr_c = '0;
    sum        = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req2_c[i]) begin
        sum = int'(rr_q) + i;
        if (sum >= int'(NCH)) sum = sum - int'(NCH);
        gnt_vld_c = 1'b1;
        gnt_ch_c  = CH_W'(sum);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (gnt_ch_c == CH_W'(c)) gnt_addr_c = rd_addr_i[c*BLK_W +: BLK_W];
    end
    rr_next_c = (int'(gnt_ch_c) == int'(NCH) - 1) ? '0 : gnt_ch_c + CH_W'(1);
  end

  // Tag compare across the ways of the latched set and victim choice.
  always_comb begin
    hit_c       = 1'b0;
    hit_way_c   = '0;
    vict_c      = vptr_q[op_set_q];
    all_valid_c = &valid_q[op_set_q];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[op_set_q][w] && (tag_mem[way_idx(op_set_q, WAY_W'(w))] == op_tag_q)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
      if (!valid_q[op_set_q][w]) vict_c = WAY_W'(w);
    end
    hit_line_c = data_mem[way_idx(op_set_q, hit_way_c)];
  end

  // Line delivery to a read channel, on a lookup hit or a fill.
  always_comb begin
    resp_fire_c = 1'b0;
    resp_line_c = ext_rdata_i;
    if (!op_wr_q) begin
      if (state_q == S_LOOKUP && hit_c) begin
        resp_fire_c = 1'b1;
        resp_line_c = hit_line_c;
      end else if (state_q == S_FETCH && ext_dv_i) begin
        resp_fire_c = 1'b1;
      end
    end
  end

  // Array write port: fills in FETCH, merged line in WRITE.
  always_comb begin
    merged_d    = merge_line(line_q, op_offs_q, op_data_q, op_len_q);
    mem_idx_c   = way_idx(op_set_q, way_q);
    mem_we_c    = 1'b0;
    tag_we_c    = 1'b0;
    mem_wdata_c = ext_rdata_i;
    if (state_q == S_FETCH && ext_dv_i) begin
      mem_we_c = 1'b1;
      tag_we_c = 1'b1;
    end else if (state_q == S_WRITE) begin
      mem_we_c    = 1'b1;
      mem_wdata_c = merged_d;
    end
  end

  // Tag and data storage; contents qualified by valid_q so no reset needed.
  always_ff @(posedge clk_i) begin
    if (mem_we_c) data_mem[mem_idx_c] <= mem_wdata_c;
    if (tag_we_c) tag_mem[mem_idx_c]  <= op_tag_q;
  end

  // Control FSM with registered outputs and per-set state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      op_wr_q    <= 1'b0;
      op_ch_q    <= '0;
      op_tag_q   <= '0;
      op_set_q   <= '0;
      op_offs_q  <= '0;
      op_data_q  <= '0;
      op_len_q   <= '0;
      way_q      <= '0;
      line_q     <= '0;
      rd_data_q  <= '0;
      rd_dv_q    <= '0;
      wr_ack_q   <= 1'b0;
      inv_ack_q  <= 1'b0;
      ext_rd_q   <= 1'b0;
      ext_addr_q <= '0;
      valid_q    <= '{default: '0};
      vptr_q     <= '{default: '0};
    end else begin
      rd_dv_q   <= '0;
      wr_ack_q  <= 1'b0;
      inv_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (inv_i) begin
            op_tag_q  <= inv_addr_i[BLK_W-1:SET_W];
            op_set_q  <= inv_addr_i[SET_W-1:0];
            inv_ack_q <= 1'b1;
            state_q   <= S_INV;
          end else if (wr_req_i) begin
            op_tag_q  <= wr_addr_i[BLK_W-1:SET_W];
            op_set_q  <= wr_addr_i[SET_W-1:0];
            op_wr_q   <= 1'b1;
            op_offs_q <= wr_offs_i;
            op_data_q <= wr_data_i;
            op_len_q  <= wr_len_i;
            state_q   <= S_LOOKUP;
          end else if (gnt_vld_c) begin
            op_tag_q  <= gnt_addr_c[BLK_W-1:SET_W];
            op_set_q  <= gnt_addr_c[SET_W-1:0];
            op_wr_q   <= 1'b0;
            op_ch_q   <= gnt_ch_c;
            rr_q      <= rr_next_c;
            state_q   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit_c) begin
            way_q  <= hit_way_c;
            line_q <= hit_line_c;
            if (op_wr_q) begin
              wr_ack_q <= 1'b1;
              state_q  <= S_WRITE;
            end else begin
              state_q  <= S_RESP;
            end
          end else begin
            way_q <= vict_c;
            if (all_valid_c) begin
              vptr_q[op_set_q] <= (vptr_q[op_set_q] == WAY_W'(WAYS - 1)) ?
                                  '0 : vptr_q[op_set_q] + WAY_W'(1);
            end
            ext_rd_q   <= 1'b1;
            ext_addr_q <= {op_tag_q, op_set_q};
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (ext_dv_i) begin
            ext_rd_q                <= 1'b0;
            valid_q[op_set_q][way_q] <= 1'b1;
            line_q                  <= ext_rdata_i;
            if (op_wr_q) begin
              wr_ack_q <= 1'b1;
              state_q  <= S_WRITE;
            end else begin
              state_q  <= S_RESP;
            end
          end
        end
        S_RESP:  state_q <= S_IDLE;
        S_WRITE: state_q <= S_IDLE;
        S_INV: begin
          if (hit_c) valid_q[op_set_q][hit_way_c] <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (resp_fire_c) begin
        for (int c = 0; c < NCH; c++) begin
          if (op_ch_q == CH_W'(c)) begin
            rd_data_q[c*LINE_W +: LINE_W] <= resp_line_c;
            rd_dv_q[c]                    <= 1'b1;
          end
        end
      end
    end
  end

endmodule
